// File: rtl/alu_pkg.sv
// Shared constants for the ALU result path: widths, flag bit positions and
// the occupancy encoding used by the two-entry output buffer.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int FLAG_W = 5;

    localparam int FLG_SIGN   = 0;
    localparam int FLG_ZERO   = 1;
    localparam int FLG_CARRY  = 2;
    localparam int FLG_PARITY = 3;
    localparam int FLG_OVF    = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-entry valid/ready skid buffer. Both in_ready and out_valid are
// registered, so neither side sees a combinational path from the other.
module skid_buffer2 #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import alu_pkg::*;

    occ_t             state;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // out_data is the head entry; the skid entry only fills while the head is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_data  <= '0;
            skid_data <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= TWO;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the ALU: buffers sum and flags through a
// two-entry skid buffer and keeps sticky carry/overflow plus an overflow counter.
module alu_result_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_z,
    input  logic [4:0]        in_flags,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_z,
    output logic [4:0]        out_flags,
    input  logic              sticky_clr,
    output logic              sticky_carry,
    output logic              sticky_ovf,
    output logic [CNT_W-1:0]  ovf_count
);
    import alu_pkg::*;

    logic                     accept;
    logic                     accept_ovf;
    logic [DATA_W+FLAG_W-1:0] buf_in;
    logic [DATA_W+FLAG_W-1:0] buf_out;

    assign buf_in = {in_flags, in_z};
    assign {out_flags, out_z} = buf_out;

    skid_buffer2 #(
        .WIDTH(DATA_W + FLAG_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (buf_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign accept     = in_valid & in_ready;
    assign accept_ovf = accept & in_flags[FLG_OVF];

    // A flag set on the same cycle as a clear survives the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            ovf_count    <= '0;
        end else begin
            sticky_carry <= (sticky_carry & ~sticky_clr) | (accept & in_flags[FLG_CARRY]);
            sticky_ovf   <= (sticky_ovf & ~sticky_clr) | accept_ovf;
            if (sticky_clr) begin
                ovf_count <= accept_ovf ? CNT_W'(1) : '0;
            end else if (accept_ovf && (ovf_count != {CNT_W{1'b1}})) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: reset, backpressure, streaming, carry,
// sticky clear and counter saturation (second instance with a 2-bit counter).
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_z;
    logic [4:0]  in_flags;
    logic        out_ready;
    logic        sticky_clr;

    logic        in_ready, out_valid, sticky_carry, sticky_ovf;
    logic [15:0] out_z;
    logic [4:0]  out_flags;
    logic [7:0]  ovf_count;

    logic        s_in_ready, s_out_valid, s_sticky_carry, s_sticky_ovf;
    logic [15:0] s_out_z;
    logic [4:0]  s_out_flags;
    logic [1:0]  s_ovf_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [20:0] last_exp;
    logic [15:0] rx, ry;
    int          exp_cnt;
    logic        exp_carry, exp_ovf;

    always #5 clk = ~clk;

    alu_result_stage #(.DATA_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_z(in_z), .in_flags(in_flags), .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_flags(out_flags), .sticky_clr(sticky_clr),
        .sticky_carry(sticky_carry), .sticky_ovf(sticky_ovf), .ovf_count(ovf_count)
    );

    alu_result_stage #(.DATA_W(16), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_z(in_z), .in_flags(in_flags), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_z(s_out_z), .out_flags(s_out_flags), .sticky_clr(sticky_clr),
        .sticky_carry(s_sticky_carry), .sticky_ovf(s_sticky_ovf), .ovf_count(s_ovf_count)
    );

    // Reference 16-bit adder producing {ovf, parity(even), carry, zero, sign, sum}.
    function automatic logic [20:0] alu_model(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [15:0] z;
        logic [4:0]  f;
        s = {1'b0, x} + {1'b0, y};
        z = s[15:0];
        f[0] = z[15];
        f[1] = (z == 16'h0000);
        f[2] = s[16];
        f[3] = ~^z;
        f[4] = (x[15] == y[15]) && (z[15] != x[15]);
        return {f, z};
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] x, input logic [15:0] y);
        in_valid = v;
        if (v) begin
            last_exp = alu_model(x, y);
            {in_flags, in_z} = last_exp;
        end else begin
            in_z = 'x;
            in_flags = 'x;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with a valid input pending.
        rst_n = 1'b0;
        out_ready = 1'b0;
        sticky_clr = 1'b0;
        applyStimulus(1'b1, 16'h1234, 16'h0001);
        tick();
        tick();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_ovf_count", 32'(ovf_count), 32'd0);
        checkOutput("rst_out_z", 32'(out_z), 32'd0);
        checkOutput("rst_out_flags", 32'(out_flags), 32'd0);
        checkOutput("rst_sticky", {30'd0, sticky_carry, sticky_ovf}, 32'd0);
        checkOutput("rst_sat_outs", {s_out_flags, s_out_z, s_out_valid, s_in_ready,
                    s_sticky_carry, s_sticky_ovf, s_ovf_count}, 32'h0000_0010);

        // First result after reset: 0x7FFF + 0x0001.
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h7FFF, 16'h0001);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0);
        checkOutput("first_out_valid", 32'(out_valid), 32'd1);
        checkOutput("first_out_z", 32'(out_z), 32'h8000);
        checkOutput("first_out_flags", 32'(out_flags), 32'b10001);
        checkOutput("first_sticky_ovf", 32'(sticky_ovf), 32'd1);
        checkOutput("first_sticky_carry", 32'(sticky_carry), 32'd0);
        checkOutput("first_ovf_count", 32'(ovf_count), 32'd1);
        tick();
        checkOutput("first_drained", 32'(out_valid), 32'd0);
        checkOutput("idle_x_sticky", {30'd0, sticky_carry, sticky_ovf}, 32'd1);

        // Backpressure: 1, 2, 3 back to back with the consumer stalled.
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0001, 16'h0000);
        tick();
        checkOutput("bp1_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp1_out_z", 32'(out_z), 32'h0001);
        applyStimulus(1'b1, 16'h0002, 16'h0000);
        tick();
        checkOutput("bp2_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp2_out_z", 32'(out_z), 32'h0001);
        applyStimulus(1'b1, 16'h0003, 16'h0000);
        tick();
        checkOutput("bp3_in_ready", 32'(in_ready), 32'd0);
        checkOutput("bp3_out_z_held", 32'(out_z), 32'h0001);
        checkOutput("bp3_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_drain2_z", 32'(out_z), 32'h0002);
        checkOutput("bp_drain2_in_ready", 32'(in_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0);
        checkOutput("bp_drain3_z", 32'(out_z), 32'h0003);
        checkOutput("bp_drain3_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_drain3_flags", 32'(out_flags), 32'b01000);
        tick();
        checkOutput("bp_empty", 32'(out_valid), 32'd0);

        // Clear sticky state, then stream 100 random results.
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        checkOutput("clr_ovf_count", 32'(ovf_count), 32'd0);
        checkOutput("clr_sticky", {30'd0, sticky_carry, sticky_ovf}, 32'd0);
        exp_cnt = 0;
        exp_carry = 1'b0;
        exp_ovf = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rx = 16'($urandom());
            ry = 16'($urandom());
            applyStimulus(1'b1, rx, ry);
            if (last_exp[20]) exp_cnt++;
            exp_carry |= last_exp[18];
            exp_ovf |= last_exp[20];
            tick();
            checkOutput("stream_valid", 32'(out_valid), 32'd1);
            checkOutput("stream_data", {11'd0, out_flags, out_z}, {11'd0, last_exp});
        end
        applyStimulus(1'b0, 16'h0, 16'h0);
        checkOutput("stream_ovf_count", 32'(ovf_count), 32'(exp_cnt));
        checkOutput("stream_sticky", {30'd0, sticky_carry, sticky_ovf}, {30'd0, exp_carry, exp_ovf});
        tick();
        checkOutput("stream_empty", 32'(out_valid), 32'd0);

        // Carry case: 0xFFFF + 0x0001.
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        applyStimulus(1'b1, 16'hFFFF, 16'h0001);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0);
        checkOutput("carry_out_z", 32'(out_z), 32'h0000);
        checkOutput("carry_out_flags", 32'(out_flags), 32'b01110);
        checkOutput("carry_sticky_carry", 32'(sticky_carry), 32'd1);
        checkOutput("carry_sticky_ovf", 32'(sticky_ovf), 32'd0);
        tick();

        // Clear coinciding with an accepted overflow: set wins.
        applyStimulus(1'b1, 16'h7FFF, 16'h0001);
        tick();
        checkOutput("pre_clr_count", 32'(ovf_count), 32'd1);
        sticky_clr = 1'b1;
        applyStimulus(1'b1, 16'h8000, 16'h8000);
        tick();
        applyStimulus(1'b0, 16'h0, 16'h0);
        checkOutput("clrset_sticky_ovf", 32'(sticky_ovf), 32'd1);
        checkOutput("clrset_ovf_count", 32'(ovf_count), 32'd1);
        checkOutput("clrset_sticky_carry", 32'(sticky_carry), 32'd1);
        checkOutput("clrset_out_flags", 32'(out_flags), 32'b11110);
        tick();
        sticky_clr = 1'b0;
        checkOutput("clr_only_count", 32'(ovf_count), 32'd0);
        checkOutput("clr_only_sticky", {30'd0, sticky_carry, sticky_ovf}, 32'd0);
        checkOutput("sat_start_count", 32'(s_ovf_count), 32'd0);

        // Saturation of the 2-bit counter: 1, 2, 3, 3, 3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h7FFF, 16'h0001);
            tick();
            checkOutput("sat_count", 32'(s_ovf_count), (i < 3) ? 32'(i + 1) : 32'd3);
        end
        checkOutput("wide_count", 32'(ovf_count), 32'd5);

        // Fill to two entries, then reset mid-stream.
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0005, 16'h0000);
        tick();
        checkOutput("two_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        applyStimulus(1'b1, 16'h0006, 16'h0000);
        tick();
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_data", {11'd0, out_flags, out_z}, 32'd0);
        checkOutput("midrst_counts", {22'd0, ovf_count, s_ovf_count}, 32'd0);
        checkOutput("midrst_sticky", {30'd0, sticky_carry, sticky_ovf}, 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0);
        tick();
        checkOutput("post_rst_empty", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
